aes_inv_cipher_ctrl: RTL
========================

# aes_inv_cipher_ctrl

Iterative AES inverse-cipher sequencer. It accepts one 128-bit ciphertext block and runs the decryption rounds on a single shared round datapath (InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns), one round per clock. Round keys are fetched from an external key store by index, and the plaintext is returned over a valid/ready handshake. It sits between the key-expansion storage and the block-level decrypt interface.

## Interface
- `NR`, default 10: number of rounds. Legal values are 10, 12 and 14 (AES-128/192/256). Key length is implied only by the keys the store supplies.
- `clk`  input  1  clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `in_valid`  input  1  `ciphertext` is valid.
- `in_ready`  output  1  block can accept; equals (fsm == IDLE).
- `ciphertext`  input  128  ciphertext block. Bits [127:120] are byte 0 (row 0, col 0). Byte order is column-major.
- `key_idx`  output  4  index of the round key required this cycle.
- `round_key`  input  128  key store output for `key_idx`, combinational, same cycle.
- `out_valid`  output  1  `plaintext` is valid.
- `out_ready`  input  1  consumer accepts `plaintext`.
- `plaintext`  output  128  registered result, same byte order as `ciphertext`.
- `busy`  output  1  high in ROUND and FINAL.

## Operation
- **FSM states:** IDLE, ROUND, FINAL, DONE.
- **IDLE**
  - `key_idx` = NR.
  - On `in_valid` && `in_ready`: st <= `ciphertext` ^ `round_key`; rnd <= NR-1; next state ROUND.
- **ROUND**
  - `key_idx` = rnd.
  - st <= InvMixColumns(InvSubBytes(InvShiftRows(st)) ^ `round_key`).
  - rnd <= rnd-1.
  - If rnd == 1, next state FINAL; otherwise stay in ROUND.
- **FINAL**
  - `key_idx` = 0.
  - `plaintext` <= InvSubBytes(InvShiftRows(st)) ^ `round_key`.
  - `out_valid` <= 1; next state DONE.
- **DONE**
  - Hold `plaintext` and `out_valid` stable.
  - On `out_ready`: `out_valid` <= 0; next state IDLE.
  - `plaintext` keeps its value after the transfer.
- **Input handshake:** `in_valid` in any state other than IDLE is ignored. The block does not capture it and does not stall on it.
- **No overlap:** no input is accepted in the same cycle as the output transfer, because `in_ready` is low in DONE.
- **Round counter:** rnd is 4 bits. It never wraps, because FINAL is entered at rnd == 1.
- **Arithmetic:** all GF(2^8) arithmetic is confined to the round datapath. The controller does only XOR and muxing.
- **Reset:**
  - Asserting `reset` in any state, including mid-block, forces the FSM to IDLE and discards the partial state.
  - Reset values: `out_valid` 0, `plaintext` 0, st 0, rnd 0, `busy` 0, `in_ready` 1, `key_idx` NR.

## Timing
- **Latency:** with the accept on edge E0, rounds run on edges E1..E(NR-1) and FINAL on edge E(NR). `out_valid` is first high in the cycle after E(NR). That is NR clocks after the accept: 10 for AES-128, 14 for AES-256.
- **Throughput:** one block per NR+2 cycles when `out_ready` is held high. The DONE cycle plus the IDLE cycle separate consecutive blocks.
- **Key fetch:** `key_idx` is a pure function of fsm and rnd, i.e. registered state. The key store must return `round_key` in the same cycle.
- **Key sequence:** for one block, `key_idx` presents NR, NR-1, …, 0 on consecutive cycles with no gaps.
- **Back-pressure:** `out_valid` stays high for as many cycles as `out_ready` stays low. `plaintext` is unchanged throughout.

## Structure
- **Shared package `aes_pkg`:**
  - FSM state encoding (2-bit localparams).
  - NR_AES128 = 10, NR_AES192 = 12, NR_AES256 = 14.
  - Byte-index helper constants for the column-major layout.
- **Sub-module `aes_inv_round`:** combinational, with ports st, rk, last → nxt.
  - It instantiates the team's InvShiftRows, InvSubBytes and InvMixColumns modules.
  - `last` bypasses InvMixColumns.
  - The controller instantiates exactly one `aes_inv_round`.
  - The IDLE initial AddRoundKey is a plain XOR in the controller.

## Test plan
- **AES-128 (FIPS-197 C.1), NR=10:** key 000102…0f, ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a → `plaintext` 00112233445566778899aabbccddeeff. `out_valid` rises exactly 10 clocks after the accept. `key_idx` observed as 10, 9, …, 0.
- **AES-128 (FIPS-197 App. B):** key 2b7e151628aed2a6abf7158809cf4f3c, ciphertext 3925841d02dc09fbdc118597196a0b32 → 3243f6a8885a308d313198a2e0370734.
- **AES-256 (FIPS-197 C.3), NR=14:** key 000102…1f, ciphertext 8ea2b7ca516745bfeafc49904b496089 → 00112233…eeff, 14 clocks after the accept.
- **Back-pressure and ignored input:**
  - Hold `out_ready` low for 5 cycles after `out_valid`. `plaintext` stays stable, `in_ready` stays 0, and `in_valid` pulses during ROUND/DONE are not captured.
  - Then drive `out_ready` high: transfer occurs, and `in_ready` is 1 on the next cycle.
- **Reset mid-operation:** assert `reset` at rnd == 5. Immediately: `out_valid` 0, `plaintext` 0, `busy` 0, `in_ready` 1. A fresh C.1 block after release decrypts correctly.
- **Back-to-back blocks:** C.1 then App. B with `in_valid` and `out_ready` held high. Both results are correct, and the accepts are NR+2 = 12 cycles apart.

Source files
------------

// File: rtl/aes_inv_cipher_ctrl_pkg.sv
// aes_inv_cipher_ctrl_pkg: FSM encoding, AES round counts and GF(2^8) helpers
package aes_inv_cipher_ctrl_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ROUND = 2'd1, FINAL = 2'd2, DONE = 2'd3} state_e;
  localparam int NR_AES128 = 10;
  localparam int NR_AES192 = 12;
  localparam int NR_AES256 = 14;
  localparam int NB = 16;
  // byte (row r, column c) sits at bits [127-8*(r+4c) -: 8], column-major
  function automatic int bpos(input int r, input int c);
    return 127 - 8 * (r + 4 * c);
  endfunction
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p ^= b[i] ? x : 8'h00;
      x = xtime(x);
    end
    return p;
  endfunction
  // inverse as a^254, which also maps 0 to 0 as the S-box requires
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r, p;
    r = 8'h01;
    p = a;
    for (int i = 0; i < 7; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction
  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return ginv({b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05);
  endfunction
endpackage

// File: rtl/aes_inv_cipher_ctrl_if.sv
// aes_inv_cipher_ctrl_if: block-level decrypt handshake plus key-store fetch
interface aes_inv_cipher_ctrl_if;
  logic         in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] ciphertext, round_key, plaintext;
  logic [3:0]   key_idx;
  modport master (output in_valid, ciphertext, round_key, out_ready,
                  input in_ready, key_idx, out_valid, plaintext, busy);
  modport slave (input in_valid, ciphertext, round_key, out_ready,
                 output in_ready, key_idx, out_valid, plaintext, busy);
endinterface

// File: rtl/aes_inv_cipher_ctrl_round.sv
// aes_inv_round: one combinational inverse round; last skips InvMixColumns
module aes_inv_shift_rows
  import aes_inv_cipher_ctrl_pkg::*;
(
  input  logic [127:0] d_i,
  output logic [127:0] q_o
);
  for (genvar r = 0; r < 4; r++) begin : g_r
    for (genvar c = 0; c < 4; c++) begin : g_c
      assign q_o[bpos(r, c) -: 8] = d_i[bpos(r, (c - r + 4) % 4) -: 8];
    end
  end
endmodule

module aes_inv_sub_bytes
  import aes_inv_cipher_ctrl_pkg::*;
(
  input  logic [127:0] d_i,
  output logic [127:0] q_o
);
  for (genvar i = 0; i < NB; i++) begin : g_b
    assign q_o[127-8*i -: 8] = inv_sbox(d_i[127-8*i -: 8]);
  end
endmodule

module aes_inv_mix_columns
  import aes_inv_cipher_ctrl_pkg::*;
(
  input  logic [127:0] d_i,
  output logic [127:0] q_o
);
  for (genvar c = 0; c < 4; c++) begin : g_c
    for (genvar r = 0; r < 4; r++) begin : g_r
      assign q_o[bpos(r, c) -: 8] = gmul(d_i[bpos(r, c) -: 8], 8'h0e)
                                  ^ gmul(d_i[bpos((r + 1) % 4, c) -: 8], 8'h0b)
                                  ^ gmul(d_i[bpos((r + 2) % 4, c) -: 8], 8'h0d)
                                  ^ gmul(d_i[bpos((r + 3) % 4, c) -: 8], 8'h09);
    end
  end
endmodule

module aes_inv_round (
  input  logic [127:0] st_i,
  input  logic [127:0] rk_i,
  input  logic         last_i,
  output logic [127:0] nxt_o
);
  logic [127:0] sr, sb, ark, mc;
  aes_inv_shift_rows  u_sr (.d_i(st_i), .q_o(sr));
  aes_inv_sub_bytes   u_sb (.d_i(sr),   .q_o(sb));
  assign ark = sb ^ rk_i;
  aes_inv_mix_columns u_mc (.d_i(ark),  .q_o(mc));
  assign nxt_o = last_i ? ark : mc;
endmodule

// File: rtl/aes_inv_cipher_ctrl.sv
// aes_inv_cipher_ctrl: iterative AES decrypt sequencer, one round per clock
module aes_inv_cipher_ctrl
  import aes_inv_cipher_ctrl_pkg::*;
#(
  parameter int NR = NR_AES128
) (
  input logic                 clk_i,
  input logic                 rst_i,
  aes_inv_cipher_ctrl_if.slave bus
);
  if (NR != NR_AES128 && NR != NR_AES192 && NR != NR_AES256) begin : g_bad_nr
    $error("NR must be 10, 12 or 14");
  end
  state_e       state_q, state_d;
  logic [127:0] st_q, st_d, pt_q, pt_d, nxt;
  logic [3:0]   rnd_q, rnd_d;
  aes_inv_round u_round (.st_i(st_q), .rk_i(bus.round_key), .last_i(state_q == FINAL), .nxt_o(nxt));
  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    rnd_d   = rnd_q;
    pt_d    = pt_q;
    case (state_q)
      IDLE: if (bus.in_valid) begin
        st_d    = bus.ciphertext ^ bus.round_key;
        rnd_d   = 4'(NR - 1);
        state_d = ROUND;
      end
      ROUND: begin
        st_d    = nxt;
        rnd_d   = rnd_q - 4'd1;
        state_d = rnd_q == 4'd1 ? FINAL : ROUND;
      end
      FINAL: begin
        pt_d    = nxt;
        state_d = DONE;
      end
      DONE: state_d = bus.out_ready ? IDLE : DONE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      st_q    <= '0;
      pt_q    <= '0;
      rnd_q   <= '0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      pt_q    <= pt_d;
      rnd_q   <= rnd_d;
    end
  end
  assign bus.in_ready  = state_q == IDLE;
  assign bus.busy      = state_q == ROUND || state_q == FINAL;
  assign bus.out_valid = state_q == DONE;
  assign bus.plaintext = pt_q;
  // key index comes from registered state only, so the store can answer combinationally
  assign bus.key_idx   = state_q == ROUND ? rnd_q : state_q == FINAL ? 4'd0 : 4'(NR);
endmodule
